// File: rtl/ysyx_22050550_mdu_pkg.sv
// ysyx_22050550_mdu_pkg: shared op encodings, FSM states and iteration counter width for the MDU
package ysyx_22050550_mdu_pkg;
  localparam int XLEN_DEF = 64;
  localparam int ITER_W = $clog2(XLEN_DEF) + 1;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/ysyx_22050550_mdu_divstep.sv
// ysyx_22050550_mdu_divstep: one combinational restoring-division step on unsigned magnitudes
module ysyx_22050550_mdu_divstep
  import ysyx_22050550_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] div,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] part, diff;
  logic ge;
  assign part = {rem, quo[XLEN-1]};
  assign diff = part - {1'b0, div};
  assign ge = !diff[XLEN];
  assign rem_next = ge ? diff[XLEN-1:0] : part[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ge};
endmodule

// File: rtl/ysyx_22050550_mdu.sv
// ysyx_22050550_mdu: iterative RISC-V M-extension unit, radix-2 shift-add multiply and restoring divide
module ysyx_22050550_mdu
  import ysyx_22050550_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);
  localparam int X = XLEN;
  function automatic logic [X-1:0] ext32(input logic [X-1:0] v, input logic s);
    return s ? X'($signed(v[31:0])) : X'(v[31:0]);
  endfunction
  function automatic logic [X-1:0] fmt(input logic [X-1:0] v, input logic w);
    return w ? ext32(v, 1'b1) : v;
  endfunction
  state_t state;
  logic [ITER_W-1:0] cnt;
  logic [2*X-1:0] acc, sh, acc_n, sh_n, p;
  logic [X-1:0] q, q_n, d_rem, d_quo, qq, rr, res_n;
  logic [2:0] op;
  logic wd_q, neg_q, neg_r;
  // accept-time operand conditioning; word-mode multiplies all collapse to MULW
  logic wd, is_div, sa_en, sb_en, sa, sb, div0, ovf;
  logic [2:0] op_e;
  logic [X-1:0] a, b, ma, mb, spec_res;
  logic [ITER_W-1:0] n_iter;
  assign wd = in_word && X == 64;
  assign is_div = in_op[2];
  assign op_e = (wd && !is_div) ? OP_MUL : in_op;
  assign sa_en = is_div ? !op_e[0] : op_e != OP_MULHU;
  assign sb_en = is_div ? !op_e[0] : (op_e == OP_MUL || op_e == OP_MULH);
  assign a = wd ? ext32(in_src1, sa_en) : in_src1;
  assign b = wd ? ext32(in_src2, sb_en) : in_src2;
  assign sa = sa_en & a[X-1];
  assign sb = sb_en & b[X-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;
  assign div0 = is_div && b == '0;
  assign ovf = is_div && !op_e[0] && &b &&
               (wd ? a[31:0] == 32'h8000_0000 : a == {1'b1, {(X-1){1'b0}}});
  assign spec_res = fmt(op_e[1] ? (div0 ? a : '0) : (div0 ? '1 : a), wd);
  assign n_iter = ITER_W'((wd || X == 32) ? 32 : X);
  ysyx_22050550_mdu_divstep #(.XLEN(X)) u_divstep (
    .rem(acc[X-1:0]), .quo(q), .div(sh[X-1:0]), .rem_next(d_rem), .quo_next(d_quo)
  );
  assign acc_n = op[2] ? {{X{1'b0}}, d_rem} : acc + (q[0] ? sh : '0);
  assign sh_n = op[2] ? sh : sh << 1;
  assign q_n = op[2] ? d_quo : q >> 1;
  assign p = neg_q ? -acc_n : acc_n;
  assign qq = neg_q ? -q_n : q_n;
  assign rr = neg_r ? -acc_n[X-1:0] : acc_n[X-1:0];
  assign res_n = fmt(op[2] ? (op[1] ? rr : qq) : (op == OP_MUL ? p[X-1:0] : p[2*X-1:X]), wd_q);
  assign in_ready = state == S_IDLE && !flush;
  assign out_valid = state == S_DONE;
  assign busy = state != S_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      sh <= '0;
      q <= '0;
      op <= '0;
      wd_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op <= op_e;
          wd_q <= wd;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt <= n_iter;
          acc <= '0;
          sh <= {{X{1'b0}}, is_div ? mb : ma};
          q <= is_div ? (wd ? ma << (X - 32) : ma) : mb;
          state <= (div0 || ovf) ? S_DONE : S_CALC;
          if (div0 || ovf) out_result <= spec_res;
        end
        S_CALC: begin
          acc <= acc_n;
          sh <= sh_n;
          q <= q_n;
          cnt <= cnt - 1'b1;
          if (cnt == ITER_W'(1)) begin
            state <= S_DONE;
            out_result <= res_n;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050550_mdu.sv
// tb_ysyx_22050550_mdu: directed self-checking bench for the iterative MDU
module tb_ysyx_22050550_mdu;
  logic clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, in_word = 1'b0, out_ready = 1'b1;
  logic [2:0] in_op = '0;
  logic [63:0] in_src1 = '0, in_src2 = '0;
  logic in_ready, out_valid, busy;
  logic [63:0] out_result;
  int passed = 0, total = 0;
  ysyx_22050550_mdu #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
    in_op = op;
    in_word = w;
    in_src1 = s1;
    in_src2 = s2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_src1 = 64'hdead_beef_0bad_f00d;
    in_src2 = 64'h1357_9bdf_2468_ace0;
    in_op = ~op;
    in_word = ~w;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic w, input logic [63:0] s1,
                     input logic [63:0] s2, input logic [63:0] exp, input int exp_lat);
    int lat;
    chk({tag, " ready"}, {63'd0, in_ready}, 64'd1);
    issue(op, w, s1, s2);
    wait_valid(lat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk(tag, out_result, exp);
    tick();
    chk({tag, " back idle"}, {63'd0, busy}, 64'd0);
  endtask
  initial begin
    int lat, seen;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset result", out_result, 64'd0);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    run("MUL -1*2", 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("MULH -1*-1", 3'd1, 1'b0, '1, '1, 64'd0, 65);
    run("MULHU max*max", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("MULHSU -1*2", 3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("MULW via MULHU", 3'd3, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("DIV 7/0", 3'd4, 1'b0, 64'd7, 64'd0, '1, 1);
    run("REM 7/0", 3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1);
    run("DIV ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("REM ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run("DIVW -7/2", 3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run("REMW -7/2", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("DIV 20/-3", 3'd4, 1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run("REM 20/-3", 3'd6, 1'b0, 64'd20, -64'sd3, 64'd2, 65);
    run("REMU 100/7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    // hold the result under backpressure while another request waits at the input
    out_ready = 1'b0;
    issue(3'd5, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    chk("bp latency", 64'(lat), 64'd65);
    in_op = 3'd5;
    in_word = 1'b0;
    in_src1 = 64'd50;
    in_src2 = 64'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp valid", {63'd0, out_valid}, 64'd1);
      chk("bp result", out_result, 64'd14);
      chk("bp in_ready", {63'd0, in_ready}, 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("no accept on handshake", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    // flush in IDLE blocks the pending request
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush blocks ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("flush no accept", {63'd0, busy}, 64'd0);
    in_valid = 1'b0;
    flush = 1'b0;
    issue(3'd5, 1'b0, 64'd1000, 64'd3);
    repeat (4) tick();
    chk("calc before flush", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush idle", {63'd0, busy}, 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      seen += int'(out_valid);
      tick();
    end
    chk("flush no result", 64'(seen), 64'd0);
    run("DIVU after flush", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    // reset in the middle of a multiply abandons it
    issue(3'd0, 1'b0, 64'd3, 64'd5);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid reset busy", {63'd0, busy}, 64'd0);
    chk("mid reset result", out_result, 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      seen += int'(out_valid);
      tick();
    end
    chk("mid reset no result", 64'(seen), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
